aud_session_ctrl: RTL
=====================

# aud_session_ctrl

Session controller for `AUD_inout`. It turns user play/record/stop commands into complete engine sessions. For each session it re-arms the engine through its reset, drives `AUD_RW`, the start/end addresses and `enable`, then waits for `done` or a stop. It keeps a four-slot table of recording lengths, and it sits between the front-panel command logic and the audio engine on the `MCLK` domain.

## Interface
Parameters:
- `ADDR_W`, 18: memory address width (engine addresses).
- `RST_CYC`, 96: `MCLK` cycles `AUD_RST_N` is held low (≥2 BCLK periods).
- `ARM_CYC`, 144: `MCLK` cycles after enable before `AUD_DONE` is trusted (≥3 BCLK periods).

Ports:
- `MCLK` in 1: single clock, 12.288 MHz.
- `reset` in 1: asynchronous, active-low.
- `CMD_PLAY`, `CMD_REC`, `CMD_STOP` in 1 each: one-cycle pulses, already synchronous to `MCLK`.
- `SLOT` in 2: slot index, sampled with an accepted `CMD_PLAY` or `CMD_REC`.
- `AUD_RST_N` out 1: engine reset, active-low.
- `AUD_EN` out 1: engine `enable`.
- `AUD_RW` out 1: 0 = play, 1 = record.
- `AUD_ADDR1`, `AUD_ADDR2` out `ADDR_W`: start address and exclusive end address.
- `AUD_DONE` in 1: engine `done`.
- `MEM_CURRENT` in `ADDR_W`: engine current address.
- `BUSY`, `PLAYING`, `RECORDING` out 1: status.
- `ERR` out 1: one-cycle pulse when a command is rejected.

## Operation
- Slot `s` region: start `{s,16'h0000}`, record end `{s,16'hFFFF}` (exclusive, so the last word of each region is unused).
- `len[s]` is 16 bits; all four entries clear on reset.
- Command priority in one cycle: STOP > REC > PLAY.
- State `IDLE`:
  - REC: latch slot; `AUD_RW`=1; `ADDR1`=start; `ADDR2`=record end; go to `RST`.
  - PLAY: if `len[s]`==0, pulse `ERR` and stay in `IDLE`. Otherwise `AUD_RW`=0; `ADDR1`=start; `ADDR2`=start+`len[s]`; go to `RST`.
  - STOP: no-op.
- State `RST`: `AUD_RST_N`=0 and `AUD_EN`=0 for `RST_CYC` cycles, then go to `ARM`.
- State `ARM`: `AUD_RST_N`=1, `AUD_EN`=1. Count `ARM_CYC` cycles, ignoring `AUD_DONE` (the engine reports done spuriously before it latches addresses). Then go to `RUN`.
- State `RUN`: `AUD_EN`=1.
  - `AUD_DONE`=1: go to `FIN`.
  - STOP: for a record session, latch `MEM_CURRENT[15:0]` as the length; go to `FIN` with an abort flag.
- State `FIN`, one cycle:
  - Record: write `len[s]` = 16'hFFFF on done, or the latched value on stop.
  - Then `AUD_EN`=0, `AUD_RST_N`=0, go to `IDLE`.
- In `IDLE`, `AUD_RST_N` stays low; the engine is held reset between sessions.
- STOP in `RST` or `ARM`: go to `FIN`. A record session stopped here stores length 0.
- PLAY or REC while `BUSY`: ignored, `ERR` pulses.
- Address arithmetic: `ADDR2` = start + `len`, computed in `ADDR_W` bits. It never carries out of the slot region because `len` ≤ 16'hFFFF.

## Timing
- Reset values:
  - State `IDLE`.
  - `AUD_RST_N`=0, `AUD_EN`=0, `AUD_RW`=0.
  - `AUD_ADDR1`=`AUD_ADDR2`=0.
  - `BUSY`=`PLAYING`=`RECORDING`=`ERR`=0.
  - All `len`=0.
- An accepted command at edge N gives: state `RST`, `BUSY`=1, addresses valid at N+1. Addresses stay stable until return to `IDLE`.
- `AUD_EN` rises at N+1+`RST_CYC`. `AUD_DONE` is first sampled at N+1+`RST_CYC`+`ARM_CYC`.
- `AUD_DONE` high in `RUN` gives `FIN` next cycle and `IDLE` the cycle after. `BUSY` falls on entry to `IDLE`.
- `PLAYING` = `BUSY` & ~`AUD_RW`; `RECORDING` = `BUSY` & `AUD_RW`. Both are registered.
- `ERR` is high exactly one cycle, the cycle after the rejected command.
- Asynchronous reset mid-session: all outputs immediately return to reset values. A partial recording is discarded (its length stays 0).

## Configuration
- `AUD_LOOP_PLAY_EN` defined:
  - A play session reaching `AUD_DONE` returns from `FIN` to `RST` with identical addresses, looping until STOP.
  - `PLAYING` stays high across iterations.
  - Record sessions are unaffected.
- Undefined: every play session ends in `IDLE` after one pass.

## Structure
- Package `aud_pkg`:
  - State enum (`IDLE`, `RST`, `ARM`, `RUN`, `FIN`).
  - Constants `AUD_ADDR_W`=18, `AUD_SLOT_W`=2, `AUD_SLOT_LEN_W`=16.
  - Slot start/end helper functions.
- One sub-module: `aud_slot_table`, 4×16 length registers with a read port and a write port plus a clear on reset.
- The FSM and counters live in the top level.

## Test plan
- Reset, then PLAY with `SLOT`=1 and `len`=0: `ERR` pulses once, `BUSY` stays 0, `AUD_RST_N` stays 0.
- REC `SLOT`=2, with the engine model asserting done when `MEM_CURRENT`=`ADDR2`:
  - `ADDR1`=18'h20000, `ADDR2`=18'h2FFFF, `AUD_RW`=1.
  - `AUD_EN` rises 97 cycles after the command.
  - Afterwards `len[2]`=16'hFFFF.
- REC `SLOT`=0 with `MEM_CURRENT`=18'h01234 at STOP: `len[0]`=16'h1234. A following PLAY `SLOT`=0 drives `ADDR2`=18'h01234, `AUD_RW`=0.
- Model drives `AUD_DONE`=1 throughout `ARM`: no early exit; `FIN` is reached only from `RUN`.
- Same-cycle PLAY+REC in `IDLE` starts a record session. Same-cycle REC+STOP in `IDLE` does nothing. REC while busy pulses `ERR` and leaves the addresses unchanged.
- `reset` low mid-`RUN`: `AUD_EN`=0 and `BUSY`=0 immediately; all `len` read 0. With `AUD_LOOP_PLAY_EN` defined, play on `SLOT`=3 re-enters `RST` after each done until STOP.

Source files
------------

// File: rtl/aud_session_ctrl_pkg.sv
// Shared types, widths and slot-region address helpers for the audio session controller.
package aud_pkg;

  localparam int AUD_ADDR_W     = 18;
  localparam int AUD_SLOT_W     = 2;
  localparam int AUD_SLOT_LEN_W = 16;

  typedef enum logic [2:0] {IDLE, RST, ARM, RUN, FIN} aud_state_e;

  function automatic logic [AUD_ADDR_W-1:0] slot_start(input logic [AUD_SLOT_W-1:0] s);
    return {s, {AUD_SLOT_LEN_W{1'b0}}};
  endfunction

  // Exclusive end, so the last word of every slot region is never written.
  function automatic logic [AUD_ADDR_W-1:0] slot_rec_end(input logic [AUD_SLOT_W-1:0] s);
    return {s, {AUD_SLOT_LEN_W{1'b1}}};
  endfunction

  function automatic logic [AUD_ADDR_W-1:0] slot_play_end(input logic [AUD_SLOT_W-1:0]     s,
                                                         input logic [AUD_SLOT_LEN_W-1:0] len);
    return slot_start(s) + AUD_ADDR_W'(len);
  endfunction

endpackage

// File: rtl/aud_session_ctrl_if.sv
// Command, status and engine-control bundle between front panel, controller and audio engine.
interface aud_session_ctrl_if import aud_pkg::*; #(parameter int ADDR_W = AUD_ADDR_W);

  logic                  CMD_PLAY;
  logic                  CMD_REC;
  logic                  CMD_STOP;
  logic [AUD_SLOT_W-1:0] SLOT;
  logic                  AUD_RST_N;
  logic                  AUD_EN;
  logic                  AUD_RW;
  logic [ADDR_W-1:0]     AUD_ADDR1;
  logic [ADDR_W-1:0]     AUD_ADDR2;
  logic                  AUD_DONE;
  logic [ADDR_W-1:0]     MEM_CURRENT;
  logic                  BUSY;
  logic                  PLAYING;
  logic                  RECORDING;
  logic                  ERR;

  modport master (
    input  CMD_PLAY, CMD_REC, CMD_STOP, SLOT, AUD_DONE, MEM_CURRENT,
    output AUD_RST_N, AUD_EN, AUD_RW, AUD_ADDR1, AUD_ADDR2, BUSY, PLAYING, RECORDING, ERR
  );

  modport slave (
    output CMD_PLAY, CMD_REC, CMD_STOP, SLOT, AUD_DONE, MEM_CURRENT,
    input  AUD_RST_N, AUD_EN, AUD_RW, AUD_ADDR1, AUD_ADDR2, BUSY, PLAYING, RECORDING, ERR
  );

endinterface

// File: rtl/aud_session_ctrl_slot_table.sv
// Four-entry table of recording lengths: combinational read port, one write port, cleared on reset.
module aud_slot_table
  import aud_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [AUD_SLOT_W-1:0]     rd_slot_i,
  output logic [AUD_SLOT_LEN_W-1:0] rd_len_o,
  input  logic                      wr_en_i,
  input  logic [AUD_SLOT_W-1:0]     wr_slot_i,
  input  logic [AUD_SLOT_LEN_W-1:0] wr_len_i
);

  localparam int N_SLOTS = 2 ** AUD_SLOT_W;

  logic [AUD_SLOT_LEN_W-1:0] len_q [N_SLOTS];

  // NOTE: this small array is deliberately reset so an aborted or reset session never leaves
  // a stale length behind; larger RAM-style storage would normally be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SLOTS; i++) len_q[i] <= '0;
    end else if (wr_en_i) begin
      len_q[wr_slot_i] <= wr_len_i;
    end
  end

  assign rd_len_o = len_q[rd_slot_i];

endmodule

// File: rtl/aud_session_ctrl.sv
// Session controller: sequences engine reset, arm and run for play/record sessions per slot.
// Optional build macro AUD_LOOP_PLAY_EN makes play sessions loop until STOP.
module aud_session_ctrl
  import aud_pkg::*;
#(
  parameter int ADDR_W  = AUD_ADDR_W,
  parameter int RST_CYC = 96,
  parameter int ARM_CYC = 144
) (
  input  logic               MCLK,
  input  logic               reset,
  aud_session_ctrl_if.master bus
);

`ifdef AUD_LOOP_PLAY_EN
  localparam bit LOOP_PLAY = 1'b1;
`else
  localparam bit LOOP_PLAY = 1'b0;
`endif

  localparam int CNT_MAX = (RST_CYC > ARM_CYC) ? RST_CYC : ARM_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  aud_state_e                state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [AUD_SLOT_W-1:0]     slot_q;
  logic [AUD_SLOT_LEN_W-1:0] len_lat_q;
  logic                      abort_q;
  logic                      rst_n_q, en_q, rw_q, busy_q, playing_q, recording_q, err_q;
  logic [ADDR_W-1:0]         addr1_q, addr2_q;

  logic                      stop_c, rec_c, play_c;
  logic [AUD_SLOT_LEN_W-1:0] rd_len;
  logic                      tbl_we;
  logic                      unused_mem_hi;

  assign stop_c = bus.CMD_STOP;
  assign rec_c  = bus.CMD_REC  & ~bus.CMD_STOP;
  assign play_c = bus.CMD_PLAY & ~bus.CMD_REC & ~bus.CMD_STOP;

  assign tbl_we        = (state_q == FIN) & rw_q;
  assign unused_mem_hi = ^bus.MEM_CURRENT[ADDR_W-1:AUD_SLOT_LEN_W];

  aud_slot_table u_slot_table (
    .clk       (MCLK),
    .rst_n     (reset),
    .rd_slot_i (bus.SLOT),
    .rd_len_o  (rd_len),
    .wr_en_i   (tbl_we),
    .wr_slot_i (slot_q),
    .wr_len_i  (len_lat_q)
  );

  // NOTE: every state and output register uses non-blocking assignment so all of them update
  // together from the values sampled at the same edge.
  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      slot_q      <= '0;
      len_lat_q   <= '0;
      abort_q     <= 1'b0;
      rst_n_q     <= 1'b0;
      en_q        <= 1'b0;
      rw_q        <= 1'b0;
      busy_q      <= 1'b0;
      playing_q   <= 1'b0;
      recording_q <= 1'b0;
      err_q       <= 1'b0;
      addr1_q     <= '0;
      addr2_q     <= '0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rec_c || (play_c && rd_len != '0)) begin
            slot_q      <= bus.SLOT;
            rw_q        <= rec_c;
            addr1_q     <= ADDR_W'(slot_start(bus.SLOT));
            addr2_q     <= rec_c ? ADDR_W'(slot_rec_end(bus.SLOT))
                                 : ADDR_W'(slot_play_end(bus.SLOT, rd_len));
            len_lat_q   <= '0;
            abort_q     <= 1'b0;
            busy_q      <= 1'b1;
            recording_q <= rec_c;
            playing_q   <= ~rec_c;
            cnt_q       <= '0;
            state_q     <= RST;
          end else if (play_c) begin
            err_q <= 1'b1;
          end
        end
        // The counter includes the entry edge, so enable rises RST_CYC+1 edges after the command.
        RST: begin
          if (stop_c) begin
            abort_q <= 1'b1;
            state_q <= FIN;
          end else if (cnt_q == CNT_W'(RST_CYC)) begin
            rst_n_q <= 1'b1;
            en_q    <= 1'b1;
            cnt_q   <= '0;
            state_q <= ARM;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        // Done is spurious here; RUN is entered one edge early so done is first sampled ARM_CYC
        // edges after enable rose.
        ARM: begin
          if (stop_c) begin
            abort_q <= 1'b1;
            state_q <= FIN;
          end else if (cnt_q == CNT_W'(ARM_CYC - 2)) begin
            state_q <= RUN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (stop_c) begin
            if (rw_q) len_lat_q <= bus.MEM_CURRENT[AUD_SLOT_LEN_W-1:0];
            abort_q <= 1'b1;
            state_q <= FIN;
          end else if (bus.AUD_DONE) begin
            len_lat_q <= '1;
            state_q   <= FIN;
          end
        end
        FIN: begin
          rst_n_q <= 1'b0;
          en_q    <= 1'b0;
          if (LOOP_PLAY && !rw_q && !abort_q) begin
            cnt_q   <= '0;
            state_q <= RST;
          end else begin
            busy_q      <= 1'b0;
            playing_q   <= 1'b0;
            recording_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      if ((rec_c || play_c) && state_q != IDLE) err_q <= 1'b1;
    end
  end

  assign bus.AUD_RST_N = rst_n_q;
  assign bus.AUD_EN    = en_q;
  assign bus.AUD_RW    = rw_q;
  assign bus.AUD_ADDR1 = addr1_q;
  assign bus.AUD_ADDR2 = addr2_q;
  assign bus.BUSY      = busy_q;
  assign bus.PLAYING   = playing_q;
  assign bus.RECORDING = recording_q;
  assign bus.ERR       = err_q;

endmodule
